// File: rtl/mdu_hilo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mdu_hilo
// Description : Iterative multiply/divide unit with architectural HI/LO
//               registers. Divide datapath is built only when MDU_DIV_EN is
//               defined; otherwise DIV/DIVU complete in one cycle as no-ops.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_MUL     = 2'd1;
`ifdef MDU_DIV_EN
    localparam logic [1:0] c_DIV     = 2'd2;
`endif
    localparam logic [1:0] c_FINISH  = 2'd3;
    localparam logic [2:0] c_OP_MTHI = 3'b100;
    localparam logic [2:0] c_OP_MTLO = 3'b101;
    localparam logic [4:0] c_LAST    = 5'd31;

    logic [1:0]       r_state;
    logic [4:0]       r_count;
    logic             r_isDiv;
    logic             r_negQ;
    logic [WIDTH-1:0] r_addend;
    logic [WIDTH-1:0] r_accHi;
    logic [WIDTH-1:0] r_accLo;

    logic             w_negA;
    logic             w_negB;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH:0]   w_mulSum;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prodFix;

    // Op[0] marks the signed variants (MULT=001, DIV=011)
    assign w_negA    = Op[0] & OperandA[WIDTH-1];
    assign w_negB    = Op[0] & OperandB[WIDTH-1];
    assign w_absA    = w_negA ? -OperandA : OperandA;
    assign w_absB    = w_negB ? -OperandB : OperandB;
    assign w_mulSum  = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_addend} : '0);
    assign w_prod    = {r_accHi, r_accLo};
    assign w_prodFix = r_negQ ? -w_prod : w_prod;

`ifdef MDU_DIV_EN
    logic             r_negR;
    logic             r_divZero;
    logic [WIDTH:0]   w_partial;
    logic             w_fits;
    logic [WIDTH-1:0] w_diff;

    // Partial remainder never exceeds 2*divisor, so the low word of the
    // difference is exact whenever the trial subtraction succeeds.
    assign w_partial = {r_accHi, r_accLo[WIDTH-1]};
    assign w_fits    = (w_partial >= {1'b0, r_addend});
    assign w_diff    = w_partial[WIDTH-1:0] - r_addend;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_count   <= '0;
            r_isDiv   <= 1'b0;
            r_negQ    <= 1'b0;
            r_addend  <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
`ifdef MDU_DIV_EN
            r_negR    <= 1'b0;
            r_divZero <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        if (!Op[2]) begin
                            r_count <= '0;
                            r_isDiv <= Op[1];
                            r_negQ  <= w_negA ^ w_negB;
                            r_accHi <= '0;
                            Busy    <= 1'b1;
                            if (Op[1]) begin
                                r_addend <= w_absB;
                                r_accLo  <= w_absA;
`ifdef MDU_DIV_EN
                                r_negR    <= w_negA;
                                r_divZero <= (OperandB == '0);
                                r_state   <= c_DIV;
`else
                                r_state   <= c_FINISH;
`endif
                            end else begin
                                r_addend <= w_absA;
                                r_accLo  <= w_absB;
                                r_state  <= c_MUL;
                            end
                        end else if (Op == c_OP_MTHI) begin
                            Hi <= OperandA;
                        end else if (Op == c_OP_MTLO) begin
                            Lo <= OperandA;
                        end
                    end
                end
                c_MUL: begin
                    r_accHi <= w_mulSum[WIDTH:1];
                    r_accLo <= {w_mulSum[0], r_accLo[WIDTH-1:1]};
                    r_count <= r_count + 5'd1;
                    if (r_count == c_LAST) r_state <= c_FINISH;
                end
`ifdef MDU_DIV_EN
                c_DIV: begin
                    r_accHi <= w_fits ? w_diff : w_partial[WIDTH-1:0];
                    r_accLo <= {r_accLo[WIDTH-2:0], w_fits};
                    r_count <= r_count + 5'd1;
                    if (r_count == c_LAST) r_state <= c_FINISH;
                end
`endif
                c_FINISH: begin
`ifdef MDU_DIV_EN
                    if (r_isDiv) begin
                        Lo <= r_divZero ? '1 : (r_negQ ? -r_accLo : r_accLo);
                        Hi <= r_negR ? -r_accHi : r_accHi;
                    end else begin
                        {Hi, Lo} <= w_prodFix;
                    end
`else
                    // Without divide hardware a divide request leaves HI/LO alone
                    if (!r_isDiv) {Hi, Lo} <= w_prodFix;
`endif
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_hilo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mdu_hilo
// Description : Self-checking bench for mdu_hilo: directed vector table,
//               multi-cycle corner sequences and randomized model checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_hilo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] OperandA = '0;
    logic [31:0] OperandB = '0;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int errors = 0;
    int checks = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op),
        .OperandA(OperandA), .OperandB(OperandB),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural result computed directly from the arithmetic definition
    function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 64'(a) * 64'(b);
            3'd1: return 64'(sa * sb);
`ifdef MDU_DIV_EN
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
`endif
            default: return {mHi, mLo};
        endcase
    endfunction

    function automatic int latOf(input logic [2:0] op);
`ifdef MDU_DIV_EN
        return 33;
`else
        return op[1] ? 1 : 33;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one arithmetic op at a negedge; scramble inputs while it runs
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo, input string tag);
        int cyc;
        bit busyOk;
        for (int i = 0; i < 100 && Busy; i++) @(negedge clk);
        Start = 1'b1; Op = op; OperandA = a; OperandB = b;
        @(negedge clk);
        Start = 1'b0; Op = 3'($urandom); OperandA = $urandom; OperandB = $urandom;
        cyc = 0;
        busyOk = 1'b1;
        while (!Done && cyc < 60) begin
            if (!Busy) busyOk = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), 64'(latOf(op)));
        check({tag, " busy-during"}, 64'(busyOk), 64'd1);
        check({tag, " busy-at-done"}, 64'(Busy), 64'd0);
        check({tag, " hi"}, 64'(Hi), 64'(eHi));
        check({tag, " lo"}, 64'(Lo), 64'(eLo));
        mHi = eHi;
        mLo = eLo;
    endtask

    // MTHI/MTLO/reserved: one-edge effect, no Busy, no Done
    task automatic mtOp(input logic [2:0] op, input logic [31:0] a, input string tag);
        Start = 1'b1; Op = op; OperandA = a; OperandB = $urandom;
        @(negedge clk);
        Start = 1'b0;
        if (op == 3'd4) mHi = a;
        if (op == 3'd5) mLo = a;
        check({tag, " mt hi"}, 64'(Hi), 64'(mHi));
        check({tag, " mt lo"}, 64'(Lo), 64'(mLo));
        check({tag, " mt busy"}, 64'(Busy), 64'd0);
        check({tag, " mt done"}, 64'(Done), 64'd0);
    endtask

    initial begin
        logic [63:0] exp;
        logic [2:0]  op;
        logic [31:0] a, b;
        int cyc;
        bit sawDone;

        // Directed vectors
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
        vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
        vecs.push_back('{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
`ifdef MDU_DIV_EN
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        vecs.push_back('{3'd2, 32'd100,       32'd7,         32'd2,         32'd14});
        vecs.push_back('{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{3'd2, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
        vecs.push_back('{3'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
`else
        // Previous result (7 * -3) must survive a divide request
        vecs.push_back('{3'd2, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
        vecs.push_back('{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFEB});
`endif

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("reset hi", 64'(Hi), 64'd0);
        check("reset lo", 64'(Lo), 64'd0);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        // Start during Busy (MTHI at E10) must be ignored
        Start = 1'b1; Op = 3'd0; OperandA = 32'd3; OperandB = 32'd5;
        @(negedge clk);
        Start = 1'b0;
        cyc = 0;
        while (!Done && cyc < 60) begin
            Start = (cyc == 9);
            Op = 3'd4; OperandA = 32'h0000_AAAA;
            @(negedge clk);
            cyc++;
        end
        Start = 1'b0;
        check("ignore latency", 64'(cyc), 64'd33);
        check("ignore hi", 64'(Hi), 64'd0);
        check("ignore lo", 64'(Lo), 64'd15);
        mHi = 32'd0;
        mLo = 32'd15;
        mtOp(3'd4, 32'h0000_1234, "mthi");
        mtOp(3'd5, 32'hCAFE_F00D, "mtlo");
        mtOp(3'd6, 32'h1111_1111, "rsv6");
        mtOp(3'd7, 32'h2222_2222, "rsv7");

        // Reset in the middle of a multiply
        Start = 1'b1; Op = 3'd0; OperandA = 32'hDEAD_BEEF; OperandB = 32'h1234_5678;
        @(negedge clk);
        Start = 1'b0;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset hi", 64'(Hi), 64'd0);
        check("midreset lo", 64'(Lo), 64'd0);
        check("midreset busy", 64'(Busy), 64'd0);
        check("midreset done", 64'(Done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mHi = '0;
        mLo = '0;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (Done || Busy) sawDone = 1'b1;
        end
        check("midreset no done", 64'(sawDone), 64'd0);
        exp = refModel(3'd1, 32'hFFFF_FFFF, 32'd2);
        runOp(3'd1, 32'hFFFF_FFFF, 32'd2, exp[63:32], exp[31:0], "postreset");

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (!op[2]) begin
                exp = refModel(op, a, b);
                runOp(op, a, b, exp[63:32], exp[31:0], $sformatf("rnd%0d op%0d", n, op));
            end else begin
                mtOp(op, a, $sformatf("rnd%0d op%0d", n, op));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
